// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register feeding the ALU.
// Holds one instruction with its operands, extends the immediate, applies
// write-back forwarding at capture and while stalled, and counts stall cycles.
module id_ex_stage #(
    parameter logic FWD_EN = 1'b1,
    parameter int   CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_instr,
    input  logic [31:0]      i_rs_data,
    input  logic [31:0]      i_rt_data,
    input  logic             i_flush,
    input  logic             i_wb_en,
    input  logic [4:0]       i_wb_reg,
    input  logic [31:0]      i_wb_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_value1,
    output logic [31:0]      o_value2,
    output logic [5:0]       o_opcode,
    output logic [5:0]       o_func,
    output logic [4:0]       o_dest_reg,
    output logic             o_reg_write,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_stall_cnt
);

    logic             r_out_valid;
    logic [31:0]      r_value1;
    logic [31:0]      r_value2;
    logic [5:0]       r_opcode;
    logic [5:0]       r_func;
    logic [4:0]       r_dest_reg;
    logic             r_reg_write;
    logic             r_illegal;
    logic [4:0]       r_rs_idx;
    logic [4:0]       r_rt_idx;
    logic             r_v2_is_reg;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [5:0]  w_opcode;
    logic [5:0]  w_func;
    logic [4:0]  w_rs_idx;
    logic [4:0]  w_rt_idx;
    logic        w_is_rtype;
    logic        w_legal;
    logic [4:0]  w_dest;
    logic        w_rs_fwd;
    logic        w_rt_fwd;
    logic [31:0] w_value1;
    logic [31:0] w_value2;
    logic        w_accept;
    logic        w_hold;
    logic        w_hold_fwd1;
    logic        w_hold_fwd2;
    logic        w_wb_live;

    assign w_opcode   = i_instr[31:26];
    assign w_func     = i_instr[5:0];
    assign w_rs_idx   = i_instr[25:21];
    assign w_rt_idx   = i_instr[20:16];
    assign w_is_rtype = (w_opcode == 6'd0);
    assign w_dest     = w_is_rtype ? i_instr[15:11] : i_instr[20:16];

    assign o_in_ready = !r_out_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_hold     = r_out_valid && !i_out_ready;

    // A write-back to $0 is never a real value, so it is never forwarded.
    assign w_wb_live   = FWD_EN && i_wb_en && (i_wb_reg != 5'd0);
    assign w_rs_fwd    = w_wb_live && (i_wb_reg == w_rs_idx);
    assign w_rt_fwd    = w_wb_live && (i_wb_reg == w_rt_idx) && w_is_rtype;
    assign w_hold_fwd1 = w_wb_live && w_hold && (i_wb_reg == r_rs_idx);
    assign w_hold_fwd2 = w_wb_live && w_hold && r_v2_is_reg && (i_wb_reg == r_rt_idx);

    // Decode the offered word: legality check and operand B selection.
    always_comb begin
        w_legal  = 1'b0;
        w_value1 = w_rs_fwd ? i_wb_data : i_rs_data;
        w_value2 = w_rt_fwd ? i_wb_data : i_rt_data;
        case (w_opcode)
            6'd0: begin
                case (w_func)
                    6'd32, 6'd33, 6'd36, 6'd37, 6'd24: w_legal = 1'b1;
                    default:                           w_legal = 1'b0;
                endcase
            end
            6'd8, 6'd9: begin
                w_legal  = 1'b1;
                w_value2 = {{16{i_instr[15]}}, i_instr[15:0]};
            end
            6'd12, 6'd13: begin
                w_legal  = 1'b1;
                w_value2 = {16'd0, i_instr[15:0]};
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Occupancy: flush wins, then accept, then consume.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_out_valid <= 1'b0;
        else if (i_flush)
            r_out_valid <= 1'b0;
        else if (w_accept)
            r_out_valid <= 1'b1;
        else if (r_out_valid && i_out_ready)
            r_out_valid <= 1'b0;
    end

    // Payload capture on accept, and in-place operand refresh while stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_value1    <= 32'd0;
            r_value2    <= 32'd0;
            r_opcode    <= 6'd0;
            r_func      <= 6'd0;
            r_dest_reg  <= 5'd0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            r_rs_idx    <= 5'd0;
            r_rt_idx    <= 5'd0;
            r_v2_is_reg <= 1'b0;
        end else if (!i_flush) begin
            if (w_accept) begin
                r_value1    <= w_value1;
                r_value2    <= w_value2;
                r_opcode    <= w_opcode;
                r_func      <= w_func;
                r_dest_reg  <= w_dest;
                r_reg_write <= w_legal && (w_dest != 5'd0);
                r_illegal   <= !w_legal;
                r_rs_idx    <= w_rs_idx;
                r_rt_idx    <= w_rt_idx;
                r_v2_is_reg <= w_is_rtype;
            end else begin
                if (w_hold_fwd1)
                    r_value1 <= i_wb_data;
                if (w_hold_fwd2)
                    r_value2 <= i_wb_data;
            end
        end
    end

    // Saturating count of cycles the ALU leaves a valid instruction waiting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_stall_cnt <= '0;
        else if (w_hold && !i_flush && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign o_out_valid = r_out_valid;
    assign o_value1    = r_value1;
    assign o_value2    = r_value2;
    assign o_opcode    = r_opcode;
    assign o_func      = r_func;
    assign o_dest_reg  = r_dest_reg;
    assign o_reg_write = r_reg_write;
    assign o_illegal   = r_illegal;
    assign o_stall_cnt = r_stall_cnt;

endmodule
